// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of decode/execute status inputs and hold/flush strobes exchanged
// between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
  logic [5:0]  i_id_reg1_rd_addr;
  logic [5:0]  i_id_reg2_rd_addr;
  logic        i_ex_reg_we;
  logic [4:0]  i_ex_reg_wr_addr;
  logic        i_ex_is_load;
  logic        i_ex_jump_flag;
  logic        i_ex_mc_start;
  logic        i_ex_mc_done;
  logic        o_hold_pc;
  logic        o_hold_if_id;
  logic        o_hold_id_ex;
  logic        o_flush_if_id;
  logic        o_flush_id_ex;
  logic [1:0]  o_state;
  logic [31:0] o_stall_cnt;
  logic        o_mc_timeout;

  // Pipeline side: drives the stage status, consumes the strobes.
  modport master (
    output i_id_reg1_rd_addr, i_id_reg2_rd_addr, i_ex_reg_we, i_ex_reg_wr_addr,
           i_ex_is_load, i_ex_jump_flag, i_ex_mc_start, i_ex_mc_done,
    input  o_hold_pc, o_hold_if_id, o_hold_id_ex, o_flush_if_id, o_flush_id_ex,
           o_state, o_stall_cnt, o_mc_timeout
  );

  // Controller side.
  modport slave (
    input  i_id_reg1_rd_addr, i_id_reg2_rd_addr, i_ex_reg_we, i_ex_reg_wr_addr,
           i_ex_is_load, i_ex_jump_flag, i_ex_mc_start, i_ex_mc_done,
    output o_hold_pc, o_hold_if_id, o_hold_id_ex, o_flush_if_id, o_flush_id_ex,
           o_state, o_stall_cnt, o_mc_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use bubbles,
// multi-cycle EX freeze with timeout, and jump/branch flushing of younger stages.
module pipe_hazard_ctrl #(
  parameter int LOAD_LAT    = 1,   // bubbles per load-use hazard, 1..15
  parameter int FLUSH_EXTRA = 0,   // extra flush cycles after a jump, 0..15
  parameter int MC_TIMEOUT  = 64   // max cycles in MULTI, 2..255
) (
  input  logic               i_clk,
  input  logic               i_rst,   // asynchronous, active low
  pipe_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_MULTI   = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam bit         HAS_FLUSH   = (FLUSH_EXTRA > 0);
  localparam bit         HAS_LDSTALL = (LOAD_LAT > 1);
  localparam logic [7:0] FLUSH_INIT  = 8'(FLUSH_EXTRA);
  localparam logic [7:0] LD_INIT     = 8'(LOAD_LAT - 1);
  localparam logic [7:0] MC_INIT     = 8'(MC_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q;
  logic        timeout_q;
  logic        timeout_set;

  logic        rs1_match, rs2_match, hazard;
  logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;

  // Load-use detection; bit 5 of the decode addresses only marks "in use".
  always_comb begin
    rs1_match = (bus.i_id_reg1_rd_addr[4:0] == bus.i_ex_reg_wr_addr) &&
                (bus.i_id_reg1_rd_addr != 6'd0);
    rs2_match = (bus.i_id_reg2_rd_addr[4:0] == bus.i_ex_reg_wr_addr) &&
                (bus.i_id_reg2_rd_addr != 6'd0);
    hazard    = bus.i_ex_reg_we && bus.i_ex_is_load &&
                (bus.i_ex_reg_wr_addr != 5'd0) && (rs1_match || rs2_match);
  end

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    hold_id_ex  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state_q)
      ST_RUN, ST_LDSTALL: begin
        if (bus.i_ex_jump_flag) begin
          // A resolved jump kills both younger stages and preempts any stall.
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = HAS_FLUSH ? ST_FLUSH : ST_RUN;
          cnt_d       = HAS_FLUSH ? FLUSH_INIT : 8'd0;
        end else if (state_q == ST_LDSTALL) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_RUN;
        end else if (bus.i_ex_mc_start) begin
          // Start and done together means the op finished in one cycle.
          if (!bus.i_ex_mc_done) begin
            hold_pc    = 1'b1;
            hold_if_id = 1'b1;
            hold_id_ex = 1'b1;
            state_d    = ST_MULTI;
            cnt_d      = MC_INIT;
          end
        end else if (hazard) begin
          hold_pc     = 1'b1;
          hold_if_id  = 1'b1;
          flush_id_ex = 1'b1;
          if (HAS_LDSTALL) begin
            state_d = ST_LDSTALL;
            cnt_d   = LD_INIT;
          end
        end
      end
      ST_MULTI: begin
        // Jumps cannot resolve while EX is occupied, so the flag is ignored.
        if (bus.i_ex_mc_done) begin
          state_d = ST_RUN;
        end else if (cnt_q == 8'd0) begin
          // Abort: drop the stuck instruction from id_ex and resume.
          timeout_set = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = ST_RUN;
        end else begin
          hold_pc    = 1'b1;
          hold_if_id = 1'b1;
          hold_id_ex = 1'b1;
          cnt_d      = cnt_q - 8'd1;
        end
      end
      ST_FLUSH: begin
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
        if (bus.i_ex_jump_flag) begin
          cnt_d = FLUSH_INIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, countdown, saturating stall counter and sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= 8'd0;
      stall_cnt_q <= 32'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout_set) timeout_q <= 1'b1;
      if (hold_pc && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  // Strobes are forced low while reset is asserted.
  assign bus.o_hold_pc     = i_rst & hold_pc;
  assign bus.o_hold_if_id  = i_rst & hold_if_id;
  assign bus.o_hold_id_ex  = i_rst & hold_id_ex;
  assign bus.o_flush_if_id = i_rst & flush_if_id;
  assign bus.o_flush_id_ex = i_rst & flush_id_ex;
  assign bus.o_state       = state_q;
  assign bus.o_stall_cnt   = stall_cnt_q;
  assign bus.o_mc_timeout  = timeout_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core; sits beside the IF/ID, ID/EX and PC registers.
- Detects load-use hazards between the decode stage's source registers and an in-flight load in EX.
- Freezes the front end while a multi-cycle EX operation (future RV32M) runs, and flushes younger stages on a taken jump or branch.
- Drives hold and flush strobes to the PC, if_id and id_ex registers, and keeps a stall-cycle performance counter and a sticky timeout error flag.

Parameters:
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard; legal range 1..15.
- FLUSH_EXTRA, 0, extra flush cycles after the jump cycle; legal range 0..15.
- MC_TIMEOUT, 64, maximum cycles spent in MULTI before abort; legal range 2..255.

Ports:
- i_clk  in  1  core clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_id_reg1_rd_addr  in  6  rs1 address from decode; 0 means unused.
- i_id_reg2_rd_addr  in  6  rs2 address from decode; 0 means unused.
- i_ex_reg_we  in  1  EX instruction writes a register.
- i_ex_reg_wr_addr  in  5  EX destination register.
- i_ex_is_load  in  1  EX instruction is a load.
- i_ex_jump_flag  in  1  taken branch/jump resolved in EX this cycle.
- i_ex_mc_start  in  1  EX began a multi-cycle operation this cycle.
- i_ex_mc_done  in  1  multi-cycle result valid this cycle.
- o_hold_pc  out  1  PC keeps its value.
- o_hold_if_id  out  1  if_id keeps its value.
- o_hold_id_ex  out  1  id_ex keeps its value.
- o_flush_if_id  out  1  if_id loads a NOP.
- o_flush_id_ex  out  1  id_ex loads a NOP.
- o_state  out  2  current FSM state.
- o_stall_cnt  out  32  cycles with o_hold_pc=1, saturating.
- o_mc_timeout  out  1  sticky error: a multi-cycle op exceeded MC_TIMEOUT.

Behaviour:
- Reset (i_rst=0, asynchronous): state=RUN(0), internal down-counter=0, o_stall_cnt=0, o_mc_timeout=0. All five strobes are forced to 0 while in reset.
- Strobes are combinational from state, counter and inputs; state and counters update on the rising edge of i_clk.
- hazard = i_ex_reg_we & i_ex_is_load & (i_ex_reg_wr_addr!=0) & ((i_id_reg1_rd_addr[4:0]==i_ex_reg_wr_addr & i_id_reg1_rd_addr!=0) | (same test for reg2)). Bit 5 of each address is ignored except in the nonzero check.
- States: RUN=0, LDSTALL=1, MULTI=2, FLUSH=3.
- RUN, priority order jump > mc_start > hazard:
  - jump: o_flush_if_id=1, o_flush_id_ex=1, no holds. If FLUSH_EXTRA>0: next=FLUSH, cnt=FLUSH_EXTRA. Otherwise stay RUN.
  - mc_start & mc_done in the same cycle: single-cycle completion, no strobes, stay RUN.
  - mc_start alone: o_hold_pc=o_hold_if_id=o_hold_id_ex=1; next=MULTI, cnt=MC_TIMEOUT-1.
  - hazard: o_hold_pc=o_hold_if_id=1, o_flush_id_ex=1 (bubble). If LOAD_LAT>1: next=LDSTALL, cnt=LOAD_LAT-1. Otherwise stay RUN.
- LDSTALL: same strobes as the hazard cycle. cnt decrements each cycle; when cnt==1, next=RUN. A jump here takes RUN jump semantics and preempts the stall.
- MULTI: all three holds=1 while !i_ex_mc_done.
  - done: holds drop to 0 in the same cycle; next=RUN.
  - Otherwise cnt decrements. When cnt==0 without done: o_mc_timeout<=1 (sticky until reset), o_flush_id_ex=1 that cycle, holds=0, next=RUN.
  - i_ex_jump_flag is ignored in MULTI.
- FLUSH: both flush strobes=1, no holds. cnt decrements; when cnt==1, next=RUN. A jump here reloads cnt=FLUSH_EXTRA.
- o_stall_cnt increments on every clock edge where o_hold_pc=1; saturates at 32'hFFFF_FFFF.
- Reset asserted mid-operation in any state returns to RUN immediately; the interrupted operation is discarded.

Test Plan:
- Reset, then release with idle inputs -> o_state=0, all strobes 0, o_stall_cnt=0, o_mc_timeout=0.
- LOAD_LAT=1. EX: load, we=1, wr_addr=5; ID rs2=5 -> exactly one cycle with hold_pc=hold_if_id=flush_id_ex=1, o_stall_cnt=1. Repeat with wr_addr=0 -> no stall.
- LOAD_LAT=3, same hazard -> 3 consecutive bubble cycles (states RUN,LDSTALL,LDSTALL), then RUN, o_stall_cnt=3.
- mc_start, then mc_done 5 cycles later -> holds high for 5 cycles and low in the done cycle, o_stall_cnt=5. mc_start with mc_done in the same cycle -> no holds.
- MC_TIMEOUT=4, mc_start, done never asserted -> o_mc_timeout=1 after cycle 4, flush_id_ex pulses once, state=RUN. The flag stays 1 until i_rst=0.
- FLUSH_EXTRA=2. Jump and hazard in the same cycle -> flush both for 3 cycles, no hold. Then drive i_rst=0 while in MULTI -> asynchronous return to RUN with all strobes 0.
